// File: rtl/rv32i_encoder.sv
// rv32i_encoder
//   Packs field-level RV32I operations (R-type ALU, I-type ALU, LOAD, STORE,
//   NOP) into 32-bit instruction words. Each word leaves through a 2-entry
//   output FIFO together with its instruction-memory byte address.
//
// Parameters
//   ADDR_W     byte-address width of out_addr (wraps modulo 2^ADDR_W)
//   BASE_ADDR  byte address of the first word after reset (multiple of 4)
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   operation handshake
//   in_fmt              0=R, 1=I-ALU, 2=LOAD, 3=STORE, 4=NOP, 5..7 illegal
//   in_rs1/rs2/rd       register fields
//   in_funct3, in_alt   funct3 and funct7 bit 5 (SUB/SRA/SRAI)
//   in_imm              12-bit immediate
//   out_valid/out_ready FIFO head handshake
//   out_word, out_addr  head instruction word and its byte address
//   err                 sticky flag: an illegal operation was accepted
module rv32i_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [11:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_IALU  = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // FIFO state: head_reg drives out_word directly, tail_reg is the second slot.
  logic [1:0]        count_reg;
  logic [31:0]       head_reg;
  logic [31:0]       tail_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              err_reg;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        push;
  logic        pop;

  // ---------------------------------------------------------------------------
  // Field packing. Illegal operations collapse to a NOP word.
  // ---------------------------------------------------------------------------
  always_comb begin
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    case (in_fmt)
      3'd0: begin
        // funct7 bit 5 is only meaningful for ADD/SUB and SRL/SRA
        if (in_alt && (in_funct3 != 3'b000) && (in_funct3 != 3'b101)) begin
          enc_illegal = 1'b1;
        end else begin
          enc_word = {1'b0, in_alt, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
        end
      end
      3'd1: begin
        // Shift-immediates carry a 5-bit shamt plus the funct7 pattern
        if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) begin
          enc_word = {1'b0, in_alt, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IALU};
        end else begin
          enc_word = {in_imm, in_rs1, in_funct3, in_rd, OP_IALU};
        end
      end
      3'd2: begin
        case (in_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101:
            enc_word = {in_imm, in_rs1, in_funct3, in_rd, OP_LOAD};
          default: enc_illegal = 1'b1;
        endcase
      end
      3'd3: begin
        case (in_funct3)
          3'b000, 3'b001, 3'b010:
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
          default: enc_illegal = 1'b1;
        endcase
      end
      3'd4:    enc_word    = NOP_WORD;
      default: enc_illegal = 1'b1;
    endcase
  end

  // A full FIFO refuses input even when a pop happens in the same cycle.
  assign in_ready  = rst_n & (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_word  = head_reg;
  assign out_addr  = addr_reg;
  assign err       = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 2'd0;
      head_reg  <= 32'd0;
      tail_reg  <= 32'd0;
      addr_reg  <= BASE_ADDR;
      err_reg   <= 1'b0;
    end else begin
      if (push && enc_illegal) begin
        err_reg <= 1'b1;
      end
      if (pop) begin
        addr_reg <= addr_reg + ADDR_W'(4);
      end
      case (count_reg)
        2'd0: begin
          if (push) begin
            head_reg  <= enc_word;
            count_reg <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            // Head leaves and the new word replaces it directly
            head_reg <= enc_word;
          end else if (push) begin
            tail_reg  <= enc_word;
            count_reg <= 2'd2;
          end else if (pop) begin
            // head_reg keeps its value so out_word holds while empty
            count_reg <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_reg  <= tail_reg;
            count_reg <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_encoder.sv
module tb_rv32i_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [11:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [9:0]  out_addr;
  logic        err;

  // Second instance with a narrow address for the wrap check
  logic        in_valid_w;
  logic        in_ready_w;
  logic        out_valid_w;
  logic        out_ready_w;
  logic [31:0] out_word_w;
  logic [3:0]  out_addr_w;
  logic        err_w;

  int errors = 0;
  int checks = 0;

  rv32i_encoder #(.ADDR_W(10), .BASE_ADDR(10'h000)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .err(err)
  );

  rv32i_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_fmt(in_fmt), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_funct3(in_funct3), .in_alt(in_alt), .in_imm(in_imm),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_word(out_word_w), .out_addr(out_addr_w), .err(err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        alt;
    logic [11:0] imm;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder: builds the word from field positions with arithmetic.
  function automatic logic [31:0] ref_encode(input int unsigned fmt, input int unsigned rs1,
                                             input int unsigned rs2, input int unsigned rd,
                                             input int unsigned f3, input int unsigned alt,
                                             input int unsigned imm, output bit ill);
    int unsigned w;
    int unsigned immf;
    ill = 1'b0;
    w   = 32'h13;
    case (fmt)
      0: begin
        ill = (alt != 0) && !(f3 == 0 || f3 == 5);
        w = alt * 32'h4000_0000 + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h33;
      end
      1: begin
        if (f3 == 1 || f3 == 5) immf = (alt != 0 ? 32'h400 : 0) + (imm % 32);
        else immf = imm;
        w = (immf << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
      end
      2: begin
        ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        w = (imm << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h03;
      end
      3: begin
        ill = (f3 > 2);
        w = ((imm / 32) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + ((imm % 32) << 7) + 32'h23;
      end
      4: w = 32'h13;
      default: ill = 1'b1;
    endcase
    if (ill) w = 32'h13;
    return w;
  endfunction

  task automatic set_op(input logic [2:0] fmt, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [2:0] f3, input logic alt,
                        input logic [11:0] imm);
    in_fmt = fmt; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_funct3 = f3; in_alt = alt; in_imm = imm;
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUTs freshly out of reset.
  task automatic do_reset();
    in_valid = 1'b0;
    in_valid_w = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_addr", {22'd0, out_addr}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_wrap_addr", {28'd0, out_addr_w}, 32'hC);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_word;
    logic [9:0]  exp_addr;
    logic [31:0] last_head;
    logic        exp_err;
    bit          ill;
    logic [31:0] q[$];

    rst_n = 1'b1;
    in_valid = 1'b0; in_valid_w = 1'b0;
    out_ready = 1'b0; out_ready_w = 1'b0;
    set_op(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 12'd0);

    //               fmt   rs1    rs2    rd     f3    alt   imm        word          err
    vecs[0]  = '{3'd0, 5'd1,  5'd2,  5'd3,  3'd0, 1'b0, 12'h000, 32'h002081B3, 1'b0}; // ADD
    vecs[1]  = '{3'd0, 5'd1,  5'd2,  5'd3,  3'd0, 1'b1, 12'h000, 32'h402081B3, 1'b0}; // SUB
    vecs[2]  = '{3'd1, 5'd0,  5'd31, 5'd5,  3'd0, 1'b1, 12'hFFF, 32'hFFF00293, 1'b0}; // ADDI
    vecs[3]  = '{3'd1, 5'd1,  5'd9,  5'd1,  3'd5, 1'b1, 12'hFE3, 32'h4030D093, 1'b0}; // SRAI
    vecs[4]  = '{3'd2, 5'd2,  5'd17, 5'd6,  3'd2, 1'b1, 12'h008, 32'h00812303, 1'b0}; // LW
    vecs[5]  = '{3'd3, 5'd2,  5'd7,  5'd31, 3'd2, 1'b1, 12'h00C, 32'h00712623, 1'b0}; // SW
    vecs[6]  = '{3'd4, 5'd5,  5'd6,  5'd7,  3'd3, 1'b1, 12'hABC, 32'h00000013, 1'b0}; // NOP
    vecs[7]  = '{3'd0, 5'd4,  5'd5,  5'd6,  3'd5, 1'b1, 12'h000, 32'h40525333, 1'b0}; // SRA
    vecs[8]  = '{3'd6, 5'd1,  5'd2,  5'd3,  3'd0, 1'b0, 12'h123, 32'h00000013, 1'b1}; // fmt 6
    vecs[9]  = '{3'd2, 5'd2,  5'd0,  5'd6,  3'd3, 1'b0, 12'h008, 32'h00000013, 1'b1}; // LOAD f3=011
    vecs[10] = '{3'd0, 5'd1,  5'd2,  5'd3,  3'd1, 1'b1, 12'h000, 32'h00000013, 1'b1}; // R alt f3=001
    vecs[11] = '{3'd3, 5'd2,  5'd7,  5'd0,  3'd4, 1'b0, 12'h00C, 32'h00000013, 1'b1}; // STORE f3=100

    @(posedge clk); #1;
    do_reset();

    // ---- table-driven single operations, one cycle latency each ----
    exp_addr = 10'h000;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_op(vecs[i].fmt, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].f3, vecs[i].alt, vecs[i].imm);
      in_valid = 1'b1;
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("vec %0d: fmt=%0d word=0x%08h addr=0x%03h err=%0b", i, vecs[i].fmt, out_word, out_addr, err);
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_word", i), out_word, vecs[i].word);
      check($sformatf("vec%0d_addr", i), {22'd0, out_addr}, {22'd0, exp_addr});
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      @(posedge clk); #1;
      exp_addr = exp_addr + 10'd4;
      check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // ---- err stays set through 10 legal operations ----
    for (int i = 0; i < 10; i++) begin
      set_op(3'd0, 5'($urandom), 5'($urandom), 5'($urandom), 3'd0, 1'b0, 12'd0);
      exp_word = ref_encode(0, in_rs1, in_rs2, in_rd, 0, 0, 0, ill);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("sticky %0d: word=0x%08h err=%0b", i, out_word, err);
      check($sformatf("sticky%0d_word", i), out_word, exp_word);
      check($sformatf("sticky%0d_err", i), {31'd0, err}, 32'd1);
    end
    @(posedge clk); #1;
    do_reset();

    // ---- backpressure: 3 ops offered with out_ready low ----
    out_ready = 1'b0;
    set_op(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 12'd0);
    in_valid = 1'b1;
    check("bp_ready_a", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    set_op(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 12'd0);
    check("bp_ready_b", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    set_op(3'd1, 5'd0, 5'd0, 5'd5, 3'd0, 1'b0, 12'hFFF);
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      $display("bp hold %0d: word=0x%08h addr=0x%03h", i, out_word, out_addr);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_word", out_word, 32'h002081B3);
      check("bp_hold_addr", {22'd0, out_addr}, 32'h000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    $display("bp drain: word=0x%08h addr=0x%03h", out_word, out_addr);
    check("bp_drain1_word", out_word, 32'h402081B3);
    check("bp_drain1_addr", {22'd0, out_addr}, 32'h004);
    check("bp_drain1_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("bp drain: word=0x%08h addr=0x%03h", out_word, out_addr);
    check("bp_drain2_word", out_word, 32'hFFF00293);
    check("bp_drain2_addr", {22'd0, out_addr}, 32'h008);
    @(posedge clk); #1;
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_empty_addr", {22'd0, out_addr}, 32'h00C);
    check("bp_empty_word_hold", out_word, 32'hFFF00293);

    // ---- address wrap on the narrow instance ----
    out_ready = 1'b0;
    out_ready_w = 1'b1;
    set_op(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 12'd0);
    in_valid_w = 1'b1;
    @(posedge clk); #1;
    set_op(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b1, 12'd0);
    $display("wrap: word=0x%08h addr=0x%01h", out_word_w, out_addr_w);
    check("wrap_addr0", {28'd0, out_addr_w}, 32'hC);
    check("wrap_word0", out_word_w, 32'h002081B3);
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    $display("wrap: word=0x%08h addr=0x%01h", out_word_w, out_addr_w);
    check("wrap_addr1", {28'd0, out_addr_w}, 32'h0);
    check("wrap_word1", out_word_w, 32'h402081B3);
    @(posedge clk); #1;
    check("wrap_empty", {31'd0, out_valid_w}, 32'd0);
    out_ready_w = 1'b0;

    // ---- asynchronous reset with two words queued ----
    do_reset();
    out_ready = 1'b0;
    set_op(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 12'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    set_op(3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 12'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
    check("mid_pre_err", {31'd0, err}, 32'd1);
    check("mid_pre_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    out_ready = 1'b1;
    set_op(3'd2, 5'd2, 5'd0, 5'd6, 3'd2, 1'b0, 12'h008);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("post reset: word=0x%08h addr=0x%03h", out_word, out_addr);
    check("mid_post_word", out_word, 32'h00812303);
    check("mid_post_addr", {22'd0, out_addr}, 32'h000);
    check("mid_post_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;

    // ---- randomized traffic against the queue model ----
    do_reset();
    exp_addr  = 10'h000;
    last_head = 32'd0;
    exp_err   = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit m_push;
      bit m_pop;
      int r;
      r = $urandom_range(0, 15);
      set_op(3'((r < 13) ? (r % 5) : (5 + (r % 3))), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 1'($urandom), 12'($urandom));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      exp_word  = ref_encode(in_fmt, in_rs1, in_rs2, in_rd, in_funct3, in_alt, in_imm, ill);
      check("rnd_in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2)});
      m_push = in_valid && (q.size() < 2);
      m_pop  = out_ready && (q.size() > 0);
      @(posedge clk); #1;
      if (m_pop) begin
        last_head = q.pop_front();
        $display("rnd cyc %0d: popped 0x%08h @0x%03h", cyc, last_head, exp_addr);
        exp_addr = exp_addr + 10'd4;
      end
      if (m_push) begin
        q.push_back(exp_word);
        if (ill) exp_err = 1'b1;
      end
      check("rnd_out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      check("rnd_out_word", out_word, (q.size() > 0) ? q[0] : last_head);
      check("rnd_out_addr", {22'd0, out_addr}, {22'd0, exp_addr});
      check("rnd_err", {31'd0, err}, {31'd0, exp_err});
    end

    in_valid = 1'b0;
    out_ready = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
